// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle between the counter owner (master) and the
// sequential binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output bin,
        input  ready,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output ready,
        output done,
        output bcd
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 iteration per clock.
// Legal when 10**DIGITS > 2**WIDTH - 1.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            clr,
    bin2bcd_seq_if.slave    bus
);
    localparam int BW = 4 * DIGITS;
    localparam int WW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [WW-1:0]   work;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bcd_q;
    logic            done_q;
    logic            ready_q;

    // One iteration: correct every digit field from the pre-shift value,
    // then shift the whole register left by one.
    function automatic logic [WW-1:0] dabble_step(input logic [WW-1:0] w);
        logic [WW-1:0] a;
        // NOTE: blocking assignments are correct here; this is combinational
        // scratch inside a function, not sequential state.
        a = w;
        for (int d = 0; d < DIGITS; d++) begin
            if (w[WIDTH + 4*d +: 4] >= 4'd5)
                a[WIDTH + 4*d +: 4] = w[WIDTH + 4*d +: 4] + 4'd3;
        end
        return {a[WW-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        // NOTE: every register, including the datapath, is reset so an aborted
        // conversion leaves no residue and bcd reads zero.
        if (!clr) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work    <= {{BW{1'b0}}, bus.bin};
                        cnt     <= CW'(WIDTH);
                        ready_q <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        work <= dabble_step(work);
                        cnt  <= cnt - CW'(1);
                    end else begin
                        bcd_q  <= work[WW-1:WIDTH];
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    // A held start chains straight into the next conversion so
                    // a continuous requester gets one result per WIDTH+2 cycles.
                    if (bus.start) begin
                        work  <= {{BW{1'b0}}, bus.bin};
                        cnt   <= CW'(WIDTH);
                        state <= SHIFT;
                    end else begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=3).
module tb_bin2bcd_seq;
    logic clk;
    logic clr;
    int   checks;
    int   errors;

    bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until done (bounded). n counts edges from entry, so entering one
    // cycle before the accepting edge gives n = latency + 1.
    task automatic wait_done(input logic [7:0] next_bin, input bit hold, input bit poke,
                             output int n, output logic [11:0] res,
                             output bit stable, output logic rdy1);
        logic [11:0] prev;
        prev   = bus.bcd;
        n      = 0;
        stable = 1'b1;
        rdy1   = 1'b1;
        do begin
            tick();
            n++;
            if (n == 1) begin
                rdy1    = bus.ready;
                bus.bin = next_bin;
                if (!hold) bus.start = 1'b0;
            end
            if (poke && (n == 3 || n == 5)) bus.start = 1'b1;
            else if (poke && (n == 4 || n == 6)) bus.start = 1'b0;
            if (!bus.done && bus.bcd !== prev) stable = 1'b0;
        end while (!bus.done && n < 40);
        res = bus.bcd;
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.done) pulses++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          pulses;
        logic [11:0] res;
        bit          stable;
        logic        rdy1;
        logic [11:0] exp;

        checks    = 0;
        errors    = 0;
        clr       = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;

        // 1. reset state, quiet idle
        tick();
        tick();
        check("rst_bcd", 32'(bus.bcd), 32'h000);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_ready", 32'(bus.ready), 32'h1);
        clr = 1'b1;
        count_done(5, pulses);
        check("idle_no_done", 32'(pulses), 32'd0);
        check("idle_ready", 32'(bus.ready), 32'h1);

        // 2. single conversion of 255
        bus.bin   = 8'd255;
        bus.start = 1'b1;
        wait_done(8'd255, 1'b0, 1'b0, n, res, stable, rdy1);
        check("c255_ready_low", 32'(rdy1), 32'h0);
        check("c255_latency", 32'(n - 1), 32'd9);
        check("c255_bcd", 32'(res), 32'h255);
        check("c255_ready_in_done", 32'(bus.ready), 32'h0);
        check("c255_bcd_stable", 32'(stable), 32'h1);
        tick();
        check("c255_done_1cyc", 32'(bus.done), 32'h0);
        check("c255_ready_back", 32'(bus.ready), 32'h1);
        check("c255_bcd_hold", 32'(bus.bcd), 32'h255);

        // 3. back-to-back with start held: 0, 200, 9
        bus.bin   = 8'd0;
        bus.start = 1'b1;
        wait_done(8'd200, 1'b1, 1'b0, n, res, stable, rdy1);
        check("b2b0_latency", 32'(n - 1), 32'd9);
        check("b2b0_bcd", 32'(res), 32'h000);
        check("b2b0_stable", 32'(stable), 32'h1);
        wait_done(8'd9, 1'b1, 1'b0, n, res, stable, rdy1);
        check("b2b200_spacing", 32'(n), 32'd10);
        check("b2b200_bcd", 32'(res), 32'h200);
        check("b2b200_stable", 32'(stable), 32'h1);
        wait_done(8'd9, 1'b0, 1'b0, n, res, stable, rdy1);
        check("b2b9_spacing", 32'(n), 32'd10);
        check("b2b9_bcd", 32'(res), 32'h009);
        check("b2b9_stable", 32'(stable), 32'h1);
        tick();
        check("b2b_done_low", 32'(bus.done), 32'h0);
        check("b2b_ready_back", 32'(bus.ready), 32'h1);

        // 4. 99 with bin change and extra starts during SHIFT
        bus.bin   = 8'd99;
        bus.start = 1'b1;
        wait_done(8'd1, 1'b0, 1'b1, n, res, stable, rdy1);
        check("c99_latency", 32'(n - 1), 32'd9);
        check("c99_bcd", 32'(res), 32'h099);
        count_done(14, pulses);
        check("c99_extra_ignored", 32'(pulses), 32'd0);
        check("c99_bcd_hold", 32'(bus.bcd), 32'h099);

        // 5. async abort mid-SHIFT, then fresh conversion
        bus.bin   = 8'd128;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        clr = 1'b0;
        #1;
        check("abort_bcd", 32'(bus.bcd), 32'h000);
        check("abort_ready", 32'(bus.ready), 32'h1);
        check("abort_done", 32'(bus.done), 32'h0);
        tick();
        clr = 1'b1;
        count_done(12, pulses);
        check("abort_no_done", 32'(pulses), 32'd0);
        bus.bin   = 8'd128;
        bus.start = 1'b1;
        wait_done(8'd128, 1'b0, 1'b0, n, res, stable, rdy1);
        check("c128_latency", 32'(n - 1), 32'd9);
        check("c128_bcd", 32'(res), 32'h128);
        tick();

        // 6. exhaustive sweep against a decimal reference
        for (int v = 0; v < 256; v++) begin
            exp       = 12'((v / 100) << 8 | ((v / 10) % 10) << 4 | (v % 10));
            bus.bin   = 8'(v);
            bus.start = 1'b1;
            wait_done(8'(v), 1'b0, 1'b0, n, res, stable, rdy1);
            check($sformatf("sweep_bcd_%0d", v), 32'(res), 32'(exp));
            check($sformatf("sweep_lat_%0d", v), 32'(n - 1), 32'd9);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
